// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control unit.
// MAIN_CTRL_ADDI_EN adds the addi states and makes opcode 001000 legal.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] ALUB_REG     = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SH2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_RESET     = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_READ  = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WRITE = 4'd6,
        ST_EXEC      = 4'd7,
        ST_R_WB      = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JUMP      = 4'd10
`ifdef MAIN_CTRL_ADDI_EN
        ,
        ST_ADDI_EXEC = 4'd11,
        ST_ADDI_WB   = 4'd12
`endif
    } main_state_e;

    function automatic logic op_is_legal(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: return 1'b1;
`ifdef MAIN_CTRL_ADDI_EN
            OP_ADDI: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/main_ctrl_outdec.sv
// Combinational output decode for the main control FSM: state (plus
// mem_ready in FETCH/MEM_WRITE and opcode in DECODE) to datapath controls.
module main_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  main_state_e state,
    input  logic        mem_ready,
    input  logic [5:0]  opcode,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        mem_to_reg,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  Alu_op,
    output logic [1:0]  pc_source,
    output logic        illegal_op,
    output logic        instr_done
);

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUB_REG;
        Alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        illegal_op    = 1'b0;
        instr_done    = 1'b0;

        case (state)
            ST_FETCH: begin
                // PC+4 and IR load only commit on the cycle memory delivers
                mem_read  = 1'b1;
                alu_src_b = ALUB_FOUR;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            ST_DECODE: begin
                alu_src_b  = ALUB_IMM_SH2;
                illegal_op = !op_is_legal(opcode);
                instr_done = !op_is_legal(opcode);
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
            end
            ST_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            ST_MEM_WRITE: begin
                mem_write  = 1'b1;
                i_or_d     = 1'b1;
                instr_done = mem_ready;
            end
            ST_EXEC: begin
                alu_src_a = 1'b1;
                Alu_op    = ALUOP_FUNCT;
            end
            ST_R_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                Alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                instr_done    = 1'b1;
            end
            ST_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
            end
`ifdef MAIN_CTRL_ADDI_EN
            ST_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
            end
            ST_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/main_ctrl_fsm.sv
// Multi-cycle MIPS main control: state register and next-state logic.
// Define MAIN_CTRL_ADDI_EN to add the addi execute/write-back path.
module main_ctrl_fsm
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] Alu_op,
    output logic [1:0] pc_source,
    output logic       illegal_op,
    output logic       instr_done
);

    main_state_e state;
    main_state_e state_next;
    // opcode is only valid in DECODE, so lw/sw is remembered for MEM_ADDR
    logic        is_store;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_RESET;
            is_store <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_DECODE) begin
                is_store <= (opcode == OP_SW);
            end
        end
    end

    // Memory handshake: mem_read/mem_write request an access; mem_ready high
    // in the same cycle completes it, otherwise the memory state holds.
    always_comb begin
        state_next = state;
        case (state)
            ST_RESET:     state_next = ST_FETCH;
            ST_FETCH:     state_next = mem_ready ? ST_DECODE : ST_FETCH;
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_next = ST_EXEC;
                    OP_LW, OP_SW: state_next = ST_MEM_ADDR;
                    OP_BEQ:       state_next = ST_BRANCH;
                    OP_J:         state_next = ST_JUMP;
`ifdef MAIN_CTRL_ADDI_EN
                    OP_ADDI:      state_next = ST_ADDI_EXEC;
`endif
                    default:      state_next = ST_FETCH;
                endcase
            end
            ST_MEM_ADDR:  state_next = is_store ? ST_MEM_WRITE : ST_MEM_READ;
            ST_MEM_READ:  state_next = mem_ready ? ST_MEM_WB : ST_MEM_READ;
            ST_MEM_WB:    state_next = ST_FETCH;
            ST_MEM_WRITE: state_next = mem_ready ? ST_FETCH : ST_MEM_WRITE;
            ST_EXEC:      state_next = ST_R_WB;
            ST_R_WB:      state_next = ST_FETCH;
            ST_BRANCH:    state_next = ST_FETCH;
            ST_JUMP:      state_next = ST_FETCH;
`ifdef MAIN_CTRL_ADDI_EN
            ST_ADDI_EXEC: state_next = ST_ADDI_WB;
            ST_ADDI_WB:   state_next = ST_FETCH;
`endif
            default:      state_next = ST_FETCH;
        endcase
    end

    main_ctrl_outdec u_outdec (
        .state         (state),
        .mem_ready     (mem_ready),
        .opcode        (opcode),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .Alu_op        (Alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .instr_done    (instr_done)
    );

endmodule

// File: tb/tb_main_ctrl_fsm.sv
// Directed bench for main_ctrl_fsm; honours MAIN_CTRL_ADDI_EN like the RTL.
// Output vector: {pw,pwc,iod,mr,mw,irw,m2r,rd,rw,asa,asb[2],aop[2],psrc[2],ill,done}
module tb_main_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op, instr_done;
    logic [1:0] alu_src_b, Alu_op, pc_source;
    logic [17:0] outs;

    int tests = 0;
    int fails = 0;

    localparam logic [17:0] E_ZERO        = 18'b0;
    localparam logic [17:0] E_FETCH_R     = 18'b1_0_0_1_0_1_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] E_FETCH_W     = 18'b0_0_0_1_0_0_0_0_0_0_01_00_00_0_0;
    localparam logic [17:0] E_DECODE      = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_0_0;
    localparam logic [17:0] E_DECODE_ILL  = 18'b0_0_0_0_0_0_0_0_0_0_11_00_00_1_1;
    localparam logic [17:0] E_MEM_ADDR    = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] E_MEM_READ    = 18'b0_0_1_1_0_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] E_MEM_WB      = 18'b0_0_0_0_0_0_1_0_1_0_00_00_00_0_1;
    localparam logic [17:0] E_MEM_WRITE_W = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_0;
    localparam logic [17:0] E_MEM_WRITE_D = 18'b0_0_1_0_1_0_0_0_0_0_00_00_00_0_1;
    localparam logic [17:0] E_EXEC        = 18'b0_0_0_0_0_0_0_0_0_1_00_10_00_0_0;
    localparam logic [17:0] E_R_WB        = 18'b0_0_0_0_0_0_0_1_1_0_00_00_00_0_1;
    localparam logic [17:0] E_BRANCH      = 18'b0_1_0_0_0_0_0_0_0_1_00_01_01_0_1;
    localparam logic [17:0] E_JUMP        = 18'b1_0_0_0_0_0_0_0_0_0_00_00_10_0_1;
    localparam logic [17:0] E_ADDI_EXEC   = 18'b0_0_0_0_0_0_0_0_0_1_10_00_00_0_0;
    localparam logic [17:0] E_ADDI_WB     = 18'b0_0_0_0_0_0_0_0_1_0_00_00_00_0_1;

    assign outs = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                   mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, Alu_op,
                   pc_source, illegal_op, instr_done};

    main_ctrl_fsm dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .mem_ready     (mem_ready),
        .pc_write      (pc_write),
        .pc_write_cond (pc_write_cond),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dst       (reg_dst),
        .reg_write     (reg_write),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .Alu_op        (Alu_op),
        .pc_source     (pc_source),
        .illegal_op    (illegal_op),
        .instr_done    (instr_done)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Tasks start 1 time unit after a rising edge, apply inputs, sample 2 units
    // later. rdy/op entries of -1 are don't-care and get random values.

    task automatic test_reset();
        logic [17:0] exp [3] = '{E_FETCH_R, E_DECODE, E_JUMP};
        int          op  [3] = '{-1, 6'b000010, -1};
        rst_n = 1'b0; mem_ready = 1'b1; opcode = 6'b000000;
        #1;
        tests++;
        if (outs !== E_ZERO) begin fails++; $display("FAIL reset_async: got %b, expected %b", outs, E_ZERO); end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #3;
            tests++;
            if (outs !== E_ZERO) begin fails++; $display("FAIL reset_held%0d: got %b, expected %b", i, outs, E_ZERO); end
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #2;
        tests++;
        if (outs !== E_ZERO) begin fails++; $display("FAIL reset_first_cycle: got %b, expected %b", outs, E_ZERO); end
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            opcode = (op[i] < 0) ? 6'($urandom) : 6'(op[i]);
            mem_ready = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            #2;
            tests++;
            if (outs !== exp[i]) begin fails++; $display("FAIL reset_then_j cyc%0d: got %b, expected %b", i, outs, exp[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_rtype();
        logic [17:0] exp [4] = '{E_FETCH_R, E_DECODE, E_EXEC, E_R_WB};
        for (int i = 0; i < 4; i++) begin
            opcode = (i == 1) ? 6'b000000 : 6'($urandom);
            mem_ready = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            #2;
            tests++;
            if (outs !== exp[i]) begin fails++; $display("FAIL rtype cyc%0d: got %b, expected %b", i, outs, exp[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_wait();
        logic [17:0] exp [7] = '{E_FETCH_R, E_DECODE, E_MEM_ADDR, E_MEM_READ,
                                 E_MEM_READ, E_MEM_READ, E_MEM_WB};
        int          rdy [7] = '{1, -1, -1, 0, 0, 1, -1};
        for (int i = 0; i < 7; i++) begin
            opcode = (i == 1) ? 6'b100011 : 6'($urandom);
            mem_ready = (rdy[i] < 0) ? 1'($urandom_range(0, 1)) : 1'(rdy[i]);
            #2;
            tests++;
            if (outs !== exp[i]) begin fails++; $display("FAIL lw_wait cyc%0d: got %b, expected %b", i, outs, exp[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_jump();
        logic [17:0] exp [6] = '{E_FETCH_R, E_DECODE, E_BRANCH, E_FETCH_R, E_DECODE, E_JUMP};
        int          op  [6] = '{-1, 6'b000100, -1, -1, 6'b000010, -1};
        for (int i = 0; i < 6; i++) begin
            opcode = (op[i] < 0) ? 6'($urandom) : 6'(op[i]);
            mem_ready = (i == 0 || i == 3) ? 1'b1 : 1'($urandom_range(0, 1));
            #2;
            tests++;
            if (outs !== exp[i]) begin fails++; $display("FAIL beq_j cyc%0d: got %b, expected %b", i, outs, exp[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fetch_stall();
        logic [17:0] exp [5] = '{E_FETCH_W, E_FETCH_W, E_FETCH_R, E_DECODE, E_R_WB};
        int          rdy [5] = '{0, 0, 1, -1, -1};
        logic [17:0] e;
        for (int i = 0; i < 6; i++) begin
            opcode = (i == 3) ? 6'b000000 : 6'($urandom);
            mem_ready = (i > 4 || rdy[i] < 0) ? 1'($urandom_range(0, 1)) : 1'(rdy[i]);
            e = (i == 4) ? E_EXEC : (i == 5) ? E_R_WB : exp[i];
            #2;
            tests++;
            if (outs !== e) begin fails++; $display("FAIL fetch_stall cyc%0d: got %b, expected %b", i, outs, e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        logic [17:0] exp [2] = '{E_FETCH_R, E_DECODE_ILL};
        for (int i = 0; i < 2; i++) begin
            opcode = (i == 1) ? 6'b111111 : 6'($urandom);
            mem_ready = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            #2;
            tests++;
            if (outs !== exp[i]) begin fails++; $display("FAIL illegal cyc%0d: got %b, expected %b", i, outs, exp[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_addi();
`ifdef MAIN_CTRL_ADDI_EN
        logic [17:0] exp [4] = '{E_FETCH_R, E_DECODE, E_ADDI_EXEC, E_ADDI_WB};
        localparam int N = 4;
`else
        logic [17:0] exp [2] = '{E_FETCH_R, E_DECODE_ILL};
        localparam int N = 2;
`endif
        for (int i = 0; i < N; i++) begin
            opcode = (i == 1) ? 6'b001000 : 6'($urandom);
            mem_ready = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            #2;
            tests++;
            if (outs !== exp[i]) begin fails++; $display("FAIL addi cyc%0d: got %b, expected %b", i, outs, exp[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        logic [17:0] exp [10] = '{E_FETCH_R, E_DECODE, E_MEM_ADDR, E_MEM_READ, E_MEM_WB,
                                  E_FETCH_R, E_DECODE, E_MEM_ADDR, E_MEM_WRITE_W, E_MEM_WRITE_D};
        int          rdy [10] = '{1, -1, -1, 1, -1, 1, -1, -1, 0, 1};
        int          op  [10] = '{-1, 6'b100011, -1, -1, -1, -1, 6'b101011, -1, -1, -1};
        for (int i = 0; i < 10; i++) begin
            opcode = (op[i] < 0) ? 6'($urandom) : 6'(op[i]);
            mem_ready = (rdy[i] < 0) ? 1'($urandom_range(0, 1)) : 1'(rdy[i]);
            #2;
            tests++;
            if (outs !== exp[i]) begin fails++; $display("FAIL back_to_back cyc%0d: got %b, expected %b", i, outs, exp[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_sw();
        logic [17:0] exp [5] = '{E_FETCH_R, E_DECODE, E_MEM_ADDR, E_MEM_WRITE_W, E_MEM_WRITE_W};
        int          rdy [5] = '{1, -1, -1, 0, 0};
        for (int i = 0; i < 5; i++) begin
            opcode = (i == 1) ? 6'b101011 : 6'($urandom);
            mem_ready = (rdy[i] < 0) ? 1'($urandom_range(0, 1)) : 1'(rdy[i]);
            #2;
            tests++;
            if (outs !== exp[i]) begin fails++; $display("FAIL sw_stall cyc%0d: got %b, expected %b", i, outs, exp[i]); end
            if (i < 4) begin @(posedge clk); #1; end
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (mem_write !== 1'b0 || outs !== E_ZERO) begin
            fails++; $display("FAIL sw_async_reset: got %b, expected %b", outs, E_ZERO);
        end
        @(posedge clk); #1;
        mem_ready = 1'b1;
        #2;
        tests++;
        if (outs !== E_ZERO) begin fails++; $display("FAIL sw_reset_held: got %b, expected %b", outs, E_ZERO); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        #2;
        tests++;
        if (outs !== E_ZERO) begin fails++; $display("FAIL sw_reset_release: got %b, expected %b", outs, E_ZERO); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_branch_jump();
        test_fetch_stall();
        test_illegal();
        test_addi();
        test_back_to_back();
        test_reset_mid_sw();
        test_rtype();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
